// File: rtl/motor_ramp_ctrl_pkg.sv
// motor_pkg: shared types and helpers for the dual-channel motor ramp controller.
//
// Contents:
//   DUTY_W      duty width, matches the pwmc vq input
//   SOFT_EN     1 when MOTOR_SOFTSTART_EN is defined (tick-paced ramping),
//               0 otherwise (ramps complete in one cycle, no prescaler)
//   dir_e       commanded bridge direction
//   ch_state_e  per-channel sequencer state
//   dir_pins()  maps a direction to the (in1,in2) bridge pin pair
//   is_drive()  true for FWD/REV
//
// Configuration macro: MOTOR_SOFTSTART_EN
package motor_pkg;

  localparam int DUTY_W = 13;

`ifdef MOTOR_SOFTSTART_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    COAST = 2'b00,
    FWD   = 2'b01,
    REV   = 2'b10,
    BRAKE = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RAMP = 3'd1,
    HOLD = 3'd2,
    DOWN = 3'd3,
    DEAD = 3'd4
  } ch_state_e;

  function automatic logic [1:0] dir_pins(input dir_e d);
    logic [1:0] p;
    case (d)
      FWD:     p = 2'b10;
      REV:     p = 2'b01;
      BRAKE:   p = 2'b11;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

  function automatic logic is_drive(input dir_e d);
    return (d == FWD) || (d == REV);
  endfunction

endpackage

// File: rtl/motor_ramp_ctrl_if.sv
// motor_ramp_ctrl_if: command handshake into the motor ramp controller.
//
// Signals:
//   cmd_valid  command present
//   cmd_ready  command can be accepted for the channel on cmd_ch
//   cmd_ch     channel select (0=A, 1=B)
//   cmd_dir    requested direction (dir_e)
//   cmd_duty   target duty, ignored for coast/brake
//
// Modports: master (command source), slave (controller).
interface motor_ramp_ctrl_if;
  import motor_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_ch;
  dir_e              cmd_dir;
  logic [DUTY_W-1:0] cmd_duty;

  modport master (output cmd_valid, cmd_ch, cmd_dir, cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, cmd_ch, cmd_dir, cmd_duty, output cmd_ready);

endinterface

// File: rtl/motor_ramp_ctrl_ch_seq.sv
// motor_ch_seq: one motor channel's sequencer (FSM, duty register, dead-time counter).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tick         ramp step enable from the shared prescaler
//   cmd_en       accepted command for this channel (one cycle)
//   cmd_dir      commanded direction
//   cmd_duty     commanded target duty
//   in1, in2     registered bridge direction pins
//   duty         registered duty to the PWM generator
//   busy         channel not in IDLE/HOLD
//   state        current state, used by the top for cmd_ready
//
// Configuration macro: MOTOR_SOFTSTART_EN (via motor_pkg::SOFT_EN).
module motor_ch_seq
  import motor_pkg::*;
#(
  parameter logic [DUTY_W-1:0] STEP      = 13'h0040,
  parameter int                BRAKE_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              cmd_en,
  input  dir_e              cmd_dir,
  input  logic [DUTY_W-1:0] cmd_duty,
  output logic              in1,
  output logic              in2,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output ch_state_e         state
);

  localparam int CNT_W = $clog2(BRAKE_CYC + 1);
  // Without soft-start a full-scale step reaches any target in one move.
  localparam logic [DUTY_W-1:0] STEP_EFF = SOFT_EN ? STEP : {DUTY_W{1'b1}};

  ch_state_e         state_q, state_d;
  dir_e              dir_q, dir_d, pend_dir_q, pend_dir_d;
  logic [DUTY_W-1:0] duty_q, duty_d, target_q, target_d;
  logic [DUTY_W-1:0] pend_target_q, pend_target_d;
  logic [CNT_W-1:0]  dead_cnt_q, dead_cnt_d;
  logic [1:0]        pins_q, pins_d;

  logic [DUTY_W:0]   up_sum, down_diff;
  logic [DUTY_W-1:0] ramp_duty;
  logic [DUTY_W-1:0] cmd_target;

  // One saturating step toward target; the extra bit catches overflow/underflow.
  always_comb begin
    up_sum    = {1'b0, duty_q} + {1'b0, STEP_EFF};
    down_diff = {1'b0, duty_q} - {1'b0, STEP_EFF};
    if (duty_q < target_q) begin
      ramp_duty = (up_sum > {1'b0, target_q}) ? target_q : up_sum[DUTY_W-1:0];
    end else if (down_diff[DUTY_W] || (down_diff[DUTY_W-1:0] < target_q)) begin
      ramp_duty = target_q;
    end else begin
      ramp_duty = down_diff[DUTY_W-1:0];
    end
  end

  assign cmd_target = (cmd_dir == COAST) ? '0 : cmd_duty;

  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    duty_d        = duty_q;
    target_d      = target_q;
    pend_dir_d    = pend_dir_q;
    pend_target_d = pend_target_q;
    dead_cnt_d    = dead_cnt_q;

    case (state_q)
      RAMP: if (tick) begin
        duty_d = ramp_duty;
        if (ramp_duty == target_q) begin
          if (target_q == '0) begin
            state_d = IDLE;
            dir_d   = COAST;
          end else begin
            state_d = HOLD;
          end
        end
      end
      DOWN: if (tick) begin
        duty_d = ramp_duty;
        if (ramp_duty == '0) begin
          if (pend_dir_q == COAST) begin
            state_d = IDLE;
            dir_d   = COAST;
          end else begin
            state_d    = DEAD;
            dead_cnt_d = '0;
          end
        end
      end
      DEAD: begin
        if (dead_cnt_q == CNT_W'(BRAKE_CYC - 1)) begin
          state_d       = RAMP;
          dir_d         = pend_dir_q;
          target_d      = pend_target_q;
          pend_dir_d    = COAST;
          pend_target_d = '0;
        end else begin
          dead_cnt_d = dead_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    // An accepted command overrides the autonomous step; duty holds on that cycle.
    if (cmd_en) begin
      if (cmd_dir == BRAKE) begin
        state_d       = IDLE;
        dir_d         = BRAKE;
        duty_d        = '0;
        target_d      = '0;
        pend_dir_d    = COAST;
        pend_target_d = '0;
      end else if (state_q != DEAD) begin
        duty_d = duty_q;
        if (is_drive(dir_q) && (cmd_dir == dir_q)) begin
          // Same direction: retarget, which also cancels any pending reversal.
          target_d      = cmd_target;
          pend_dir_d    = COAST;
          pend_target_d = '0;
          state_d       = ((duty_q == cmd_target) && (cmd_target != '0)) ? HOLD : RAMP;
        end else if (is_drive(dir_q)) begin
          // Leaving an active drive direction: ramp down first, or brake-dwell
          // straight away if the duty is already zero.
          target_d      = '0;
          pend_dir_d    = cmd_dir;
          pend_target_d = cmd_target;
          if (duty_q != '0) begin
            state_d = DOWN;
          end else if (cmd_dir == COAST) begin
            state_d    = IDLE;
            dir_d      = COAST;
            pend_dir_d = COAST;
          end else begin
            state_d    = DEAD;
            dead_cnt_d = '0;
          end
        end else begin
          dir_d         = cmd_dir;
          target_d      = cmd_target;
          pend_dir_d    = COAST;
          pend_target_d = '0;
          if (cmd_dir == COAST) begin
            state_d = IDLE;
          end else begin
            state_d = ((duty_q == cmd_target) && (cmd_target != '0)) ? HOLD : RAMP;
          end
        end
      end
    end

    pins_d = (state_d == DEAD) ? 2'b11 : dir_pins(dir_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dir_q         <= COAST;
      duty_q        <= '0;
      target_q      <= '0;
      pend_dir_q    <= COAST;
      pend_target_q <= '0;
      dead_cnt_q    <= '0;
      pins_q        <= 2'b00;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      duty_q        <= duty_d;
      target_q      <= target_d;
      pend_dir_q    <= pend_dir_d;
      pend_target_q <= pend_target_d;
      dead_cnt_q    <= dead_cnt_d;
      pins_q        <= pins_d;
    end
  end

  assign in1   = pins_q[1];
  assign in2   = pins_q[0];
  assign duty  = duty_q;
  assign busy  = !((state_q == IDLE) || (state_q == HOLD));
  assign state = state_q;

endmodule

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: dual-channel motor command sequencer in front of two pwmc
// generators and an H-bridge. Ramps each channel's duty toward its target and
// inserts a ramp-down plus brake dwell before any direction reversal.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd                 command handshake (motor_ramp_ctrl_if.slave)
//   ain1/ain2, bin1/bin2  bridge direction pins for channels A and B
//   duty_a, duty_b      duty to pwmc.vq
//   busy_a, busy_b      channel not in IDLE/HOLD
//   standby             bridge enable, high from the first edge after reset
//
// Configuration macro: MOTOR_SOFTSTART_EN (tick-paced ramps when defined).
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int                STEP_DIV  = 1000,
  parameter logic [DUTY_W-1:0] STEP      = 13'h0040,
  parameter int                BRAKE_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  motor_ramp_ctrl_if.slave  cmd,
  output logic              ain1,
  output logic              ain2,
  output logic              bin1,
  output logic              bin2,
  output logic [DUTY_W-1:0] duty_a,
  output logic [DUTY_W-1:0] duty_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              standby
);

  // Without soft-start the divider collapses to a constant tick.
  localparam int DIV_EFF = SOFT_EN ? STEP_DIV : 1;
  localparam int PRE_W   = $clog2(DIV_EFF + 1);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick;
  logic             standby_q, standby_d;
  ch_state_e        state_a, state_b, sel_state;
  logic             accept;

  assign tick = (pre_cnt_q == PRE_W'(DIV_EFF - 1));

  always_comb begin
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    standby_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      standby_q <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      standby_q <= standby_d;
    end
  end

  // Brake is always accepted so it can abort a dwell; standby gates ready so
  // every output reads 0 while held in reset.
  assign sel_state     = cmd.cmd_ch ? state_b : state_a;
  assign cmd.cmd_ready = standby_q && ((sel_state != DEAD) || (cmd.cmd_dir == BRAKE));
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign standby       = standby_q;

  motor_ch_seq #(.STEP(STEP), .BRAKE_CYC(BRAKE_CYC)) u_ch_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .cmd_en   (accept && !cmd.cmd_ch),
    .cmd_dir  (cmd.cmd_dir),
    .cmd_duty (cmd.cmd_duty),
    .in1      (ain1),
    .in2      (ain2),
    .duty     (duty_a),
    .busy     (busy_a),
    .state    (state_a)
  );

  motor_ch_seq #(.STEP(STEP), .BRAKE_CYC(BRAKE_CYC)) u_ch_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .cmd_en   (accept && cmd.cmd_ch),
    .cmd_dir  (cmd.cmd_dir),
    .cmd_duty (cmd.cmd_duty),
    .in1      (bin1),
    .in2      (bin2),
    .duty     (duty_b),
    .busy     (busy_b),
    .state    (state_b)
  );

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: directed self-checking bench for motor_ramp_ctrl with
// STEP_DIV=4, STEP=0x400, BRAKE_CYC=8. Expected duty sequences follow
// MOTOR_SOFTSTART_EN (multi-step ramps when defined, single jumps otherwise).
module tb_motor_ramp_ctrl;
  import motor_pkg::*;

  logic clk;
  logic rst_n;
  logic ain1, ain2, bin1, bin2;
  logic [12:0] duty_a, duty_b;
  logic busy_a, busy_b, standby;

  int checks;
  int errors;

  motor_ramp_ctrl_if bus ();

  motor_ramp_ctrl #(
    .STEP_DIV  (4),
    .STEP      (13'h400),
    .BRAKE_CYC (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (bus),
    .ain1    (ain1),
    .ain2    (ain2),
    .bin1    (bin1),
    .bin2    (bin2),
    .duty_a  (duty_a),
    .duty_b  (duty_b),
    .busy_a  (busy_a),
    .busy_b  (busy_b),
    .standby (standby)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive a command from a negedge, let one posedge accept it, return at the next negedge.
  task automatic applyStimulus(input logic ch, input dir_e dir, input logic [12:0] duty);
    bus.cmd_ch    = ch;
    bus.cmd_dir   = dir;
    bus.cmd_duty  = duty;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  function automatic logic [12:0] curDuty(input logic ch);
    return ch ? duty_b : duty_a;
  endfunction

  task automatic waitDutyChange(input logic ch, input int budget, output logic [12:0] val);
    logic [12:0] prev;
    logic changed;
    prev = curDuty(ch);
    changed = 1'b0;
    for (int i = 0; i < budget && !changed; i++) begin
      @(negedge clk);
      if (curDuty(ch) !== prev) changed = 1'b1;
    end
    checkOutput("duty_change_within_budget", changed, 1'b1);
    val = curDuty(ch);
  endtask

  logic [12:0] ramp_q[$];
  logic [12:0] down_q[$];
  logic [12:0] rev_up_q[$];
  logic [12:0] b_q[$];
  logic [12:0] bfull_q[$];
  logic [12:0] v;
  int dead_cycles;
  logic saw_brake;

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_ch = 1'b0;
    bus.cmd_dir = COAST;
    bus.cmd_duty = '0;

`ifdef MOTOR_SOFTSTART_EN
    ramp_q   = '{13'h400, 13'h800, 13'hC00, 13'h1000};
    down_q   = '{13'hC00, 13'h800, 13'h400, 13'h000};
    rev_up_q = '{13'h400, 13'h800};
    b_q      = '{13'h400, 13'h800, 13'hC00};
    bfull_q  = '{13'h400, 13'h800, 13'hC00, 13'h1000, 13'h1400, 13'h1800, 13'h1C00, 13'h1FFF};
`else
    ramp_q   = '{13'h1000};
    down_q   = '{13'h000};
    rev_up_q = '{13'h800};
    b_q      = '{13'h1FFF};
    bfull_q  = '{13'h1FFF};
`endif

    // Reset behaviour
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {ain1, ain2, bin1, bin2, duty_a, duty_b, busy_a, busy_b, standby, bus.cmd_ready}, '0);
    rst_n = 1'b1;
    #1;
    checkOutput("standby_before_edge", standby, 1'b0);
    @(negedge clk);
    checkOutput("standby_after_edge", standby, 1'b1);
    checkOutput("idle_after_reset", {ain1, ain2, duty_a, busy_a}, '0);

    // Channel A forward ramp
    applyStimulus(1'b0, FWD, 13'h1000);
    checkOutput("a_fwd_pins", {ain1, ain2}, 2'b10);
    checkOutput("a_fwd_busy", busy_a, 1'b1);
    foreach (ramp_q[i]) begin
      waitDutyChange(1'b0, 6, v);
      checkOutput("a_ramp_duty", v, ramp_q[i]);
    end
    checkOutput("a_hold_busy", busy_a, 1'b0);
    checkOutput("b_untouched", {bin1, bin2, duty_b, busy_b}, '0);

    // Reversal A: fwd 0x1000 -> rev 0x800
    applyStimulus(1'b0, REV, 13'h800);
    checkOutput("rev_accept_pins", {ain1, ain2}, 2'b10);
    checkOutput("rev_accept_busy", busy_a, 1'b1);
    foreach (down_q[i]) begin
      waitDutyChange(1'b0, 6, v);
      checkOutput("rev_down_duty", v, down_q[i]);
      checkOutput("rev_down_pins", {ain1, ain2}, (down_q[i] == 13'h0) ? 2'b11 : 2'b10);
    end
    bus.cmd_dir = REV;
    bus.cmd_ch = 1'b0;
    #1;
    checkOutput("dead_ready_a", bus.cmd_ready, 1'b0);
    bus.cmd_ch = 1'b1;
    #1;
    checkOutput("dead_ready_b", bus.cmd_ready, 1'b1);
    bus.cmd_ch = 1'b0;
    dead_cycles = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ({ain1, ain2} != 2'b11) break;
      dead_cycles++;
    end
    checkOutput("dead_cycle_count", dead_cycles, 8);
    checkOutput("rev_pins_after_dead", {ain1, ain2}, 2'b01);
    checkOutput("rev_duty_after_dead", duty_a, 13'h0);
    foreach (rev_up_q[i]) begin
      waitDutyChange(1'b0, 6, v);
      checkOutput("rev_up_duty", v, rev_up_q[i]);
    end
    checkOutput("rev_hold_busy", busy_a, 1'b0);

    // Channel B forward toward 0x1FFF, then brake partway
    applyStimulus(1'b1, FWD, 13'h1FFF);
    checkOutput("b_fwd_pins", {bin1, bin2}, 2'b10);
    foreach (b_q[i]) begin
      waitDutyChange(1'b1, 6, v);
      checkOutput("b_ramp_duty", v, b_q[i]);
    end
    applyStimulus(1'b1, BRAKE, 13'h0);
    checkOutput("b_brake_duty", duty_b, 13'h0);
    checkOutput("b_brake_pins", {bin1, bin2}, 2'b11);
    checkOutput("b_brake_busy", busy_b, 1'b0);
    checkOutput("a_during_b", {ain1, ain2, duty_a}, {2'b01, 13'h800});

    // Channel B full ramp saturates at 0x1FFF
    applyStimulus(1'b1, FWD, 13'h1FFF);
    foreach (bfull_q[i]) begin
      waitDutyChange(1'b1, 6, v);
      checkOutput("b_full_duty", v, bfull_q[i]);
    end
    checkOutput("b_full_busy", busy_b, 1'b0);

    // Reversal cancelled: A rev 0x800 -> fwd 0x600 -> rev 0x600
    applyStimulus(1'b0, FWD, 13'h600);
    checkOutput("cancel_down_pins", {ain1, ain2}, 2'b01);
    checkOutput("cancel_down_busy", busy_a, 1'b1);
    applyStimulus(1'b0, REV, 13'h600);
    saw_brake = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ({ain1, ain2} == 2'b11) saw_brake = 1'b1;
    end
    checkOutput("cancel_no_dead", saw_brake, 1'b0);
    checkOutput("cancel_duty", duty_a, 13'h600);
    checkOutput("cancel_pins", {ain1, ain2}, 2'b01);
    checkOutput("cancel_busy", busy_a, 1'b0);

    // Coast A: ramp down then pins 00
    applyStimulus(1'b0, COAST, 13'h0);
    checkOutput("coast_pins_held", {ain1, ain2}, 2'b01);
    for (int i = 0; i < 20; i++) begin
      if (!busy_a) break;
      @(negedge clk);
    end
    checkOutput("coast_duty", duty_a, 13'h0);
    checkOutput("coast_pins", {ain1, ain2}, 2'b00);

    // Reset mid-operation clears every output immediately
    applyStimulus(1'b0, FWD, 13'h1000);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midop_reset_outputs", {ain1, ain2, bin1, bin2, duty_a, duty_b, busy_a, busy_b, standby, bus.cmd_ready}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/motor_ramp_ctrl.md
# motor_ramp_ctrl

Dual-channel motor command sequencer sitting between the command source (buttons/switch decode or host logic) and the two `pwmc` PWM generators plus the H-bridge direction pins. It accepts direction and duty commands per channel, ramps each channel's 13-bit duty toward its target at a programmed rate, and enforces a ramp-down plus brake dead-time before any direction reversal so the bridge is never hard-reversed under load.

## Interface
- `DUTY_W`, 13: duty width; matches the `pwmc` `vq` input.
- `STEP_DIV`, 1000: clock cycles per ramp tick (≥1).
- `STEP`, 13'h0040: duty change per tick.
- `BRAKE_CYC`, 50000: brake dwell cycles before a reversal (≥1).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted for the channel on `cmd_ch` (combinational).
- `cmd_ch`  in  1  channel select: 0=A, 1=B.
- `cmd_dir`  in  2  00 coast, 01 forward, 10 reverse, 11 brake.
- `cmd_duty`  in  DUTY_W  target duty; ignored for coast/brake.
- `ain1`, `ain2`, `bin1`, `bin2`  out  1 each  bridge direction pins.
- `duty_a`, `duty_b`  out  DUTY_W  to `pwmc.vq`.
- `busy_a`, `busy_b`  out  1  channel not in IDLE/HOLD.
- `standby`  out  1  bridge enable.

## Operation
- Reset: all outputs 0. Both channels in IDLE, dir=coast, duty=0, prescaler=0. `standby` is registered and goes to 1 on the first clock edge after reset release.
- A command is accepted on a clock edge with `cmd_valid && cmd_ready`. `cmd_ready` is 0 only while the selected channel is in DEAD.
- Direction pin encoding (in1,in2): coast 00, forward 10, reverse 01, brake 11.
- A shared prescaler generates a one-cycle `tick` every STEP_DIV cycles. Duty changes only on ticks.
- Per-channel states:
  - IDLE: duty 0, pins reflect the current dir (coast or brake).
  - RAMP: on each tick, duty moves toward target by STEP, saturating at target. Exit to HOLD when duty==target, or to IDLE when target==0.
  - HOLD: duty==target.
  - DOWN: ramping to 0 with the old dir held. At duty==0, go to DEAD for a reversal, or to IDLE for coast.
  - DEAD: pins 11, duty 0. A counter runs BRAKE_CYC cycles, then the pending dir is applied and the channel enters RAMP.
- Command handling:
  - Same dir as current, or current duty==0 with no DEAD required: update target and enter RAMP (or HOLD if equal). Pins switch on the cycle after acceptance.
  - Opposite drive dir while duty>0: store pending dir/target and enter DOWN.
  - Command in DOWN: replaces pending. If the new dir equals the current dir, cancel the reversal and enter RAMP toward the new target.
  - Coast: target 0, enter DOWN, pins 00 once duty reaches 0.
  - Brake: immediate. Duty 0 and pins 11 on the next cycle, state IDLE, any pending command discarded. Valid from any state, including DEAD.
- Arithmetic: ramp up = min(duty+STEP, target); ramp down = max(duty−STEP, target), computed in DUTY_W+1 bits. No wrap-around.

## Timing
- Command to pin/state update: 1 cycle. Command to first duty change: next tick, at most STEP_DIV cycles.
- Full ramp 0→T: ceil(T/STEP) ticks.
- Reversal: DOWN ticks + BRAKE_CYC cycles in DEAD + ramp ticks. The pins never pass directly between 10 and 01 without at least BRAKE_CYC cycles of 11 in between.
- Asserting `rst_n` low mid-operation returns every output to 0 immediately.

## Configuration
- `MOTOR_SOFTSTART_EN` defined: ramping as described.
- Not defined: RAMP and DOWN complete in one cycle (duty = target directly, ignoring ticks), and the prescaler is removed. DEAD and the brake dwell are still enforced.

## Structure
- Package `motor_pkg`: `DUTY_W`; enum `dir_e` (COAST, FWD, REV, BRAKE); enum `ch_state_e` (IDLE, RAMP, HOLD, DOWN, DEAD); function mapping `dir_e` to the (in1,in2) pin pair.
- Sub-module `motor_ch_seq`: one channel's FSM, duty register and dead-time counter, instantiated twice. The top level holds the prescaler, command demux, `cmd_ready` mux and `standby`.

## Test plan
Bench parameters: STEP_DIV=4, STEP=13'h400, BRAKE_CYC=8, macro defined.
- Reset: hold `rst_n`=0, then release → all outputs 0 during reset; `standby`=1 one cycle after release.
- Command A fwd 0x1000 → ain1/ain2=10 next cycle; duty_a steps 0x400, 0x800, 0xC00, 0x1000 on successive ticks; `busy_a` falls on reaching HOLD; channel B unchanged.
- With A in HOLD at 0x1000 fwd, command A rev 0x800 → duty_a ramps down to 0 with pins 10; pins 11 for exactly 8 cycles with `cmd_ready`=0 while `cmd_ch`=0 and 1 while `cmd_ch`=1; then pins 01 and duty_a ramps to 0x800.
- Command B fwd 0x1FFF, then brake at duty 0xC00 → last ramp step saturates at 0x1FFF (no wrap) if reached; after the brake, duty_b=0 and pins 11 next cycle.
- Reversal cancelled: during DOWN, command the original dir at 0x600 → no DEAD phase; ramps to 0x600.
- Macro undefined: command A fwd 0x1000 → duty_a=0x1000 one cycle after acceptance; a reversal still shows 8 cycles of pins 11.
